// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues one instruction read at a time,
// and pushes each returned word with its PC into the instruction queue.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        iq_full,
  output logic        instr_push,
  output logic [31:0] pc_in,
  output logic [31:0] pc_next_in,
  output logic [31:0] instr_in,
  output logic        iq_flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MASK_W  = 4;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   pc, pc_d;
  logic [XLEN-1:0]   hold_instr, hold_instr_d;
  logic [XLEN-1:0]   hold_pc, hold_pc_d;
  logic              req_c;
  logic              push_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      hold_instr <= hold_instr_d;
      hold_pc    <= hold_pc_d;
    end
  end

  // Next-state logic; a redirect always wins over capture and push
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    hold_instr_d = hold_instr;
    hold_pc_d    = hold_pc;
    req_c        = 1'b0;
    push_c       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          req_c   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp ? S_IDLE : S_DRAIN;
        end else if (imem_resp) begin
          hold_instr_d = imem_rdata;
          hold_pc_d    = pc;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_IDLE;
        end else if (!iq_full) begin
          push_c  = 1'b1;
          pc_d    = hold_pc + PC_STEP;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // stale response is consumed here and its data discarded
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr  = pc;
  assign imem_rmask = (req_c && !rst) ? {MASK_W{1'b1}} : {MASK_W{1'b0}};
  assign instr_push = push_c && !rst;
  assign instr_in   = hold_instr;
  assign pc_in      = hold_pc;
  assign pc_next_in = hold_pc + PC_STEP;
  assign iq_flush   = redirect_valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front-end fetch stage and producer side of the instruction queue. It keeps the architectural fetch PC and issues one word read at a time to the instruction memory port. It captures each returned instruction and pushes it, with its PC and sequential next PC, into the queue, holding the instruction while the queue is full. A backend redirect flushes the queue, moves the PC to the target, and discards any read still in flight.

## Interface
Parameters:
- RESET_PC, 32'h1eceb000, fetch PC loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  read address, always equal to current fetch PC
- imem_rmask  out  4  4'hF for exactly one cycle per request, else 4'h0
- imem_rdata  in  32  read data, valid when imem_resp=1
- imem_resp  in  1  one-cycle response pulse, at least 1 cycle after request
- iq_full  in  1  queue full, from the queue
- instr_push  out  1  push strobe to the queue
- pc_in  out  32  PC of pushed instruction
- pc_next_in  out  32  pc_in + 4
- instr_in  out  32  pushed instruction word
- iq_flush  out  1  queue flush; combinational copy of redirect_valid
- redirect_valid  in  1  backend redirect; may assert in any cycle, any state
- redirect_pc  in  32  redirect target, word aligned

## Operation
- State: pc (32), hold_instr (32), hold_pc (32), FSM state. At most one read is outstanding.
- IDLE: drive imem_rmask=4'hF and imem_addr=pc, then go to WAIT.
  - If redirect_valid is high in this cycle: rmask=0, pc<=redirect_pc, stay IDLE.
- WAIT: rmask=0.
  - imem_resp and no redirect: hold_instr<=imem_rdata, hold_pc<=pc, go to HOLD.
  - imem_resp and redirect: drop data, pc<=redirect_pc, go to IDLE.
  - redirect, no resp: pc<=redirect_pc, go to DRAIN.
- HOLD: instr_in=hold_instr, pc_in=hold_pc, pc_next_in=hold_pc+4, instr_push=!iq_full && !redirect_valid.
  - Push taken: pc<=hold_pc+4, go to IDLE.
  - iq_full: stay HOLD with outputs stable.
  - redirect: no push, pc<=redirect_pc, go to IDLE.
- DRAIN: rmask=0. Waits for the stale response and ignores its data.
  - On imem_resp, go to IDLE.
  - A redirect in DRAIN updates pc and stays in DRAIN. If it coincides with resp, pc updates and the FSM goes to IDLE.
- Redirect always has priority over push and over response capture.
- Arithmetic: PC +4 is modulo 2^32; 32'hFFFFFFFC wraps to 0. No prediction; pc_next_in is always sequential.
- instr_push is never asserted while iq_full=1. The queue never sees a dropped push.

## Timing
- Reset values (registered, visible the cycle after rst sampled high):
  - State IDLE, pc=RESET_PC, hold_instr=0, hold_pc=0.
  - While rst=1, imem_rmask=0 and instr_push=0.
- First request: the first cycle with rst=0 drives rmask=F, addr=RESET_PC.
- Latency: push occurs 1 cycle after imem_resp, provided the queue is not full.
- Steady state with 1-cycle memory: request, response, push, and so on, giving one instruction per 3 cycles.
- iq_flush equals redirect_valid in the same cycle. The queue clears on that edge, so the next push lands in an empty queue.
- Reset mid-operation: everything returns to reset state on the next edge. The memory is reset concurrently, so no stale response is expected.
- iq_full is sampled combinationally in HOLD. A deassertion allows the push in that same cycle.

## Test plan
- Reset, then memory returns 32'h00000013 one cycle after the request, with iq_full=0:
  - Required: first request at addr 32'h1eceb000.
  - Push one cycle after resp with pc_in=32'h1eceb000, pc_next_in=32'h1eceb004, instr_in=32'h00000013.
  - Next rmask=F at addr 32'h1eceb004 in the cycle after the push.
- iq_full=1 for 5 cycles while in HOLD:
  - Required: instr_push=0, rmask=0, instr_in/pc_in stable throughout.
  - Exactly one push in the cycle iq_full drops.
- redirect_valid pulsed with redirect_pc=32'h1eceb100 one cycle into WAIT, response arriving 3 cycles later:
  - Required: iq_flush=1 in the redirect cycle, no push for the stale data.
  - Next request at addr 32'h1eceb100 the cycle after the stale resp.
- redirect_valid coincident with imem_resp in WAIT:
  - Required: no push, and the next cycle is IDLE requesting redirect_pc.
- redirect_valid while in HOLD with iq_full=0:
  - Required: instr_push=0 that cycle, and the held instruction is never pushed.
- Wrap: redirect to 32'hFFFFFFFC and fetch:
  - Required: pc_next_in=32'h00000000, and the next request is at addr 32'h00000000.
- rst asserted during HOLD:
  - Required: no push, and the next request is at RESET_PC.
